modulo_bit: RTL and testbench
=============================

Name: modulo_bit

Overview:
- Free-running modulo-N cycle counter for the signal-generator datapath.
- Emits a one-cycle `zero` strobe every MOD clock cycles.
- Downstream generator stages use the strobe as a bit/sample-rate tick.
- Exposes the current count for debug and phase alignment.

Parameters:
- MOD, 8, modulus (cycles per `zero` period); integer >= 1; MOD < 1 is an elaboration error.
- CW, $clog2(MOD) with minimum 1, width of the count output; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low: sampled on the clk rising edge, asserted when 0.
- zero  output  1  registered strobe; 1 for exactly one cycle each time count is 0 after reset.
- count  output  CW  registered current count value, range 0..MOD-1.

Behaviour:
- Reset (rst==0 at a rising edge):
  - count <= 0, zero <= 0.
  - Reset has priority over counting.
  - Reset mid-count abandons the current period immediately; no partial strobe.
- Counting (rst==1 at a rising edge):
  - count <= (count == MOD-1) ? 0 : count+1.
  - zero <= (next count == 0), so zero and count change on the same edge: zero==1 exactly when count==0, outside reset.
- After release (first edge with rst==1):
  - count sequence is 1, 2, ..., MOD-1, 0, 1, ...
  - First zero pulse occurs on the MOD-th rising edge after release.
  - Subsequent pulses follow every MOD cycles; duty is 1/MOD.
- The count==0 state held during reset does not produce a strobe (zero stays 0 while in reset).
- MOD==1: count stays 0, and zero is 1 on every cycle after the first edge with rst==1.
- MOD a power of two: natural wrap; equality compare still used so non-power-of-two MOD works identically.
- Outputs come directly from flops; no combinational paths from inputs to outputs.
- No X after reset: all flops have reset values.
- Before the first reset, output values are undefined.

Optional Feature:
- Macro: MODULO_BIT_PHASE_OUT_EN.
- Defined:
  - Adds output port `phase` (1 bit, registered), reset value 0.
  - `phase` toggles on every cycle where zero becomes 1, giving a square wave of period 2*MOD cycles.
- Not defined:
  - Port `phase` does not exist.
  - No toggle flop is synthesized.
  - All other behaviour is identical.

Test Plan:
- MOD=8, clk period 2 ns, rst=0 for 3 edges then 1 -> count and zero are 0 during reset; count reads 1..7, then 0 with zero=1 on the 8th edge after release; next zero on the 16th edge.
- MOD=8, run 100 ns after release -> zero pulses exactly every 8 cycles, each exactly 1 cycle wide; count never exceeds 7.
- MOD=5, run 3 periods -> count sequence 1,2,3,4,0 repeats; zero high only when count==0; checks the non-power-of-two wrap.
- MOD=8, assert rst=0 for 1 edge when count==5 -> next cycle count=0, zero=0; the following zero pulse is 8 edges after rst returns to 1.
- MOD=1, release reset -> count stays 0; zero=1 on every cycle after release, 0 during reset.
- MOD=4 with MODULO_BIT_PHASE_OUT_EN defined -> phase=0 after reset; phase toggles on each zero pulse (4th, 8th, 12th edge after release), giving an 8-cycle period.

Source files
------------

// File: rtl/modulo_bit.sv
// Free-running modulo-MOD cycle counter with a one-cycle zero strobe; MODULO_BIT_PHASE_OUT_EN adds a 2*MOD square-wave phase output.
// Latency: count and zero are registered and change on the same edge; the first strobe comes on the MOD-th edge after release.
// Backpressure: none; the counter free-runs whenever rst is high.
module modulo_bit #(
  parameter int MOD = 8,
  localparam int CW = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic          clk,
  input  logic          rst,
`ifdef MODULO_BIT_PHASE_OUT_EN
  output logic          phase,
`endif
  output logic          zero,
  output logic [CW-1:0] count
);

  generate
    if (MOD < 1) begin : g_bad_mod
      $error("modulo_bit: MOD must be >= 1");
    end
  endgenerate

  logic          last;
  logic [CW-1:0] nxt;

  // Equality compare so non-power-of-two moduli wrap exactly like powers of two.
  always_comb begin
    last = (count == CW'(MOD - 1));
    nxt  = last ? '0 : count + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      zero  <= 1'b0;
`ifdef MODULO_BIT_PHASE_OUT_EN
      phase <= 1'b0;
`endif
    end else begin
      count <= nxt;
      zero  <= (nxt == '0);
`ifdef MODULO_BIT_PHASE_OUT_EN
      phase <= phase ^ (nxt == '0);
`endif
    end
  end

endmodule

// File: tb/tb_modulo_bit.sv
// Bench for modulo_bit: four instances (MOD 8, 5, 1, 4) share clk/rst; expectations are queued per edge and compared after it.
`timescale 1ns/1ps
module tb_modulo_bit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       z8, z5, z1, z4;
  logic [2:0] c8, c5;
  logic [0:0] c1;
  logic [1:0] c4;
`ifdef MODULO_BIT_PHASE_OUT_EN
  logic       ph8, ph5, ph1, ph4;
`endif

  int checks   = 0;
  int failures = 0;
  int k        = 0;  // rising edges since release with rst high; 0 while in reset

  typedef struct packed {
    logic [3:0][7:0] cnt;
    logic [3:0]      z;
    logic            ph;
  } exp_t;

  exp_t exp_q[$];

  always #1 clk = ~clk;

  modulo_bit #(.MOD(8)) u8 (.clk(clk), .rst(rst),
`ifdef MODULO_BIT_PHASE_OUT_EN
    .phase(ph8),
`endif
    .zero(z8), .count(c8));
  modulo_bit #(.MOD(5)) u5 (.clk(clk), .rst(rst),
`ifdef MODULO_BIT_PHASE_OUT_EN
    .phase(ph5),
`endif
    .zero(z5), .count(c5));
  modulo_bit #(.MOD(1)) u1 (.clk(clk), .rst(rst),
`ifdef MODULO_BIT_PHASE_OUT_EN
    .phase(ph1),
`endif
    .zero(z1), .count(c1));
  modulo_bit #(.MOD(4)) u4 (.clk(clk), .rst(rst),
`ifdef MODULO_BIT_PHASE_OUT_EN
    .phase(ph4),
`endif
    .zero(z4), .count(c4));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input int kk);
    exp_t e;
    int   mods[4] = '{8, 5, 1, 4};
    e = '0;
    for (int i = 0; i < 4; i++) begin
      e.cnt[i] = (kk == 0) ? 8'd0 : 8'(kk % mods[i]);
      e.z[i]   = (kk != 0) && (kk % mods[i] == 0);
    end
    e.ph = ((kk / 4) % 2) == 1;
    return e;
  endfunction

  // One clock: drive rst at the falling edge, queue the expectation, compare after the rising edge.
  task automatic step(input logic r);
    exp_t e;
    @(negedge clk);
    rst = r;
    k = r ? k + 1 : 0;
    exp_q.push_back(model(k));
    @(posedge clk);
    #0.5;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      check("cnt_mod8", {5'd0, c8}, e.cnt[0]);
      check("zero_mod8", {7'd0, z8}, {7'd0, e.z[0]});
      check("cnt_mod5", {5'd0, c5}, e.cnt[1]);
      check("zero_mod5", {7'd0, z5}, {7'd0, e.z[1]});
      check("cnt_mod1", {7'd0, c1}, e.cnt[2]);
      check("zero_mod1", {7'd0, z1}, {7'd0, e.z[2]});
      check("cnt_mod4", {6'd0, c4}, e.cnt[3]);
      check("zero_mod4", {7'd0, z4}, {7'd0, e.z[3]});
`ifdef MODULO_BIT_PHASE_OUT_EN
      check("phase_mod4", {7'd0, ph4}, {7'd0, e.ph});
`endif
    end
  endtask

  initial begin
    // Reset for three edges: everything must read 0.
    for (int i = 0; i < 3; i++) step(1'b0);
    // Release: first strobes (8th/16th edge for MOD 8), then ~100 ns of free running.
    for (int i = 0; i < 70; i++) step(1'b1);
    // Advance until the MOD-8 counter reads 5, then reset for a single edge.
    for (int i = 0; i < 8 && (k % 8) != 5; i++) step(1'b1);
    checks++;
    assert (k % 8 == 5) else begin
      failures++;
      $error("FAIL align_mod8 observed=%0d expected=5", k % 8);
    end
    step(1'b0);
    // Restart: next MOD-8 strobe must be 8 edges after release.
    for (int i = 0; i < 20; i++) step(1'b1);
    // Long reset then release again to recheck reset dominance on every instance.
    for (int i = 0; i < 2; i++) step(1'b0);
    for (int i = 0; i < 12; i++) step(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
